// File: rtl/bus_arbiter.sv
// -----------------------------------------------------------------------------
// bus_arbiter: central arbiter of the shared system bus.
//   Grants ownership to one of 32 masters by fixed priority (index 31 highest,
//   the debug bridge), tracks the granted transaction until it ends, reports
//   bus idle / snoopable-burst status and, optionally, aborts hung transactions.
//
// Optional feature macro: BUS_WATCHDOG_EN
//   defined   : BUSY watchdog plus ABORT_ERR/ABORT_END error+end pulse sequence
//   undefined : BUSY waits indefinitely for endTransactionIn; busErrorOut and
//               endTransactionOut are tied low
//   The grant-to-begin timeout exists in both builds.
//
// Ports:
//   clock              in   bus clock, rising edge
//   reset              in   asynchronous active-low reset
//   busRequests[31:0]  in   level requests, one per master
//   busGrants[31:0]    out  one-hot, one-cycle grant pulse (registered)
//   busErrorOut        out  watchdog bus-error pulse (registered)
//   endTransactionOut  out  watchdog end-of-transaction pulse (registered)
//   busIdle            out  no transaction granted or in progress (registered)
//   snoopableBurst     out  current transaction is a cacheable burst (registered)
//   beginTransactionIn in   OR'd begin-transaction strobe
//   endTransactionIn   in   OR'd end-transaction strobe
//   dataValidIn        in   OR'd data-valid strobe
//   addressDataIn[1:0] in   bits [31:30] of the OR'd address/data bus
//   burstSizeIn[7:0]   in   OR'd burst size (beats minus 1)
// -----------------------------------------------------------------------------
module bus_arbiter #(
    parameter int unsigned BEGIN_WAIT     = 16,
    parameter int unsigned TIMEOUT_CYCLES = 256
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] busRequests,
    output logic [31:0] busGrants,
    output logic        busErrorOut,
    output logic        endTransactionOut,
    output logic        busIdle,
    output logic        snoopableBurst,
    input  logic        beginTransactionIn,
    input  logic        endTransactionIn,
    input  logic        dataValidIn,
    input  logic [1:0]  addressDataIn,
    input  logic [7:0]  burstSizeIn
);

    localparam int unsigned NUM_MASTERS = 32;
    localparam int unsigned IDX_W       = 5;
    // One counter serves both the begin timeout and the watchdog.
    localparam int unsigned CNT_MAX     = (TIMEOUT_CYCLES > BEGIN_WAIT) ? TIMEOUT_CYCLES
                                                                        : BEGIN_WAIT;
    localparam int unsigned CNT_W       = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        GRANT      = 3'd1,
        WAIT_BEGIN = 3'd2,
        BUSY       = 3'd3,
        ABORT_ERR  = 3'd4,
        ABORT_END  = 3'd5
    } state_t;

    state_t                   state_q, state_d;
    logic [NUM_MASTERS-1:0]   grants_q, grants_d;
    logic [CNT_W-1:0]         cnt_q, cnt_d;
    logic                     snoop_q, snoop_d;
    logic                     idle_q, idle_d;
    logic                     cacheable_burst;

    // Highest set request index; the later (higher) hit overrides lower ones.
    function automatic logic [IDX_W-1:0] top_index(input logic [NUM_MASTERS-1:0] req);
        logic [IDX_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            if (req[i]) begin
                idx = IDX_W'(i);
            end
        end
        return idx;
    endfunction

    // Cacheable space (address bits 31:30 == 0) and more than one beat.
    assign cacheable_burst = (addressDataIn == 2'b00) && (burstSizeIn != 8'd0);

`ifdef BUS_WATCHDOG_EN
    logic err_q, err_d;
    logic eot_q, eot_d;
`else
    // dataValidIn only feeds the watchdog.
    logic unused_data_valid;
    assign unused_data_valid = dataValidIn;
`endif

    // Next-state and registered-output logic.
    always_comb begin
        state_d  = state_q;
        grants_d = '0;
        cnt_d    = cnt_q;
        snoop_d  = snoop_q;
`ifdef BUS_WATCHDOG_EN
        err_d    = 1'b0;
        eot_d    = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (|busRequests) begin
                    state_d  = GRANT;
                    grants_d = NUM_MASTERS'(1) << top_index(busRequests);
                end
            end
            GRANT: begin
                state_d = WAIT_BEGIN;
                cnt_d   = '0;
            end
            WAIT_BEGIN: begin
                if (beginTransactionIn) begin
                    state_d = BUSY;
                    cnt_d   = '0;
                    snoop_d = cacheable_burst;
                end else if (cnt_q == CNT_W'(BEGIN_WAIT - 1)) begin
                    // Master never started: release the bus without an error.
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            BUSY: begin
                // End has priority over a coincident watchdog expiry.
                if (endTransactionIn) begin
                    state_d = IDLE;
                    snoop_d = 1'b0;
                end
`ifdef BUS_WATCHDOG_EN
                else if (dataValidIn) begin
                    cnt_d = '0;
                end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    state_d = ABORT_ERR;
                    err_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
`endif
            end
`ifdef BUS_WATCHDOG_EN
            ABORT_ERR: begin
                state_d = ABORT_END;
                eot_d   = 1'b1;
            end
            ABORT_END: begin
                state_d = IDLE;
                snoop_d = 1'b0;
            end
`endif
            default: begin
                state_d = IDLE;
                snoop_d = 1'b0;
            end
        endcase
        idle_d = (state_d == IDLE);
    end

    // State and output registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            grants_q <= '0;
            cnt_q    <= '0;
            snoop_q  <= 1'b0;
            idle_q   <= 1'b1;
`ifdef BUS_WATCHDOG_EN
            err_q    <= 1'b0;
            eot_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            grants_q <= grants_d;
            cnt_q    <= cnt_d;
            snoop_q  <= snoop_d;
            idle_q   <= idle_d;
`ifdef BUS_WATCHDOG_EN
            err_q    <= err_d;
            eot_q    <= eot_d;
`endif
        end
    end

    assign busGrants      = grants_q;
    assign busIdle        = idle_q;
    assign snoopableBurst = snoop_q;
`ifdef BUS_WATCHDOG_EN
    assign busErrorOut       = err_q;
    assign endTransactionOut = eot_q;
`else
    assign busErrorOut       = 1'b0;
    assign endTransactionOut = 1'b0;
`endif

endmodule

// File: tb/tb_bus_arbiter.sv
// -----------------------------------------------------------------------------
// tb_bus_arbiter: directed self-checking bench for bus_arbiter.
// Inputs change 1 time unit after a rising edge; outputs are checked there too.
// Watchdog expectations follow BUS_WATCHDOG_EN.
// -----------------------------------------------------------------------------
module tb_bus_arbiter;

    logic        clock;
    logic        reset;
    logic [31:0] busRequests;
    logic [31:0] busGrants;
    logic        busErrorOut;
    logic        endTransactionOut;
    logic        busIdle;
    logic        snoopableBurst;
    logic        beginTransactionIn;
    logic        endTransactionIn;
    logic        dataValidIn;
    logic [1:0]  addressDataIn;
    logic [7:0]  burstSizeIn;

    int total = 0;
    int bad   = 0;

    bus_arbiter dut (
        .clock              (clock),
        .reset              (reset),
        .busRequests        (busRequests),
        .busGrants          (busGrants),
        .busErrorOut        (busErrorOut),
        .endTransactionOut  (endTransactionOut),
        .busIdle            (busIdle),
        .snoopableBurst     (snoopableBurst),
        .beginTransactionIn (beginTransactionIn),
        .endTransactionIn   (endTransactionIn),
        .dataValidIn        (dataValidIn),
        .addressDataIn      (addressDataIn),
        .burstSizeIn        (burstSizeIn)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    initial begin
        clock              = 1'b0;
        reset              = 1'b0;
        busRequests        = '0;
        beginTransactionIn = 1'b0;
        endTransactionIn   = 1'b0;
        dataValidIn        = 1'b0;
        addressDataIn      = 2'b00;
        burstSizeIn        = 8'd0;

        // Reset state
        tick(); tick(); tick();
        chk32("rst_grants", busGrants, 32'h0);
        chk1("rst_idle", busIdle, 1'b1);
        chk1("rst_err", busErrorOut, 1'b0);
        chk1("rst_eot", endTransactionOut, 1'b0);
        chk1("rst_snoop", snoopableBurst, 1'b0);
        reset = 1'b1;
        tick();

        // Begin outside WAIT_BEGIN is ignored
        beginTransactionIn = 1'b1;
        tick();
        beginTransactionIn = 1'b0;
        chk1("ign_begin_idle", busIdle, 1'b1);
        chk32("ign_begin_grants", busGrants, 32'h0);

        // Single request from the debug bridge, non-burst transaction
        busRequests = 32'h8000_0000;
        tick();
        chk32("t1_grant", busGrants, 32'h8000_0000);
        chk1("t1_idle_grant", busIdle, 1'b0);
        busRequests = '0;
        tick();
        chk32("t1_grant_pulse", busGrants, 32'h0);
        beginTransactionIn = 1'b1; addressDataIn = 2'b00; burstSizeIn = 8'd0;
        tick();
        beginTransactionIn = 1'b0;
        chk1("t1_idle_busy", busIdle, 1'b0);
        chk1("t1_snoop", snoopableBurst, 1'b0);
        dataValidIn = 1'b1;
        tick();
        dataValidIn = 1'b0;
        chk1("t1_idle_data", busIdle, 1'b0);
        endTransactionIn = 1'b1;
        tick();
        endTransactionIn = 1'b0;
        chk1("t1_idle_end", busIdle, 1'b1);

        // Simultaneous requests: 31 first, 0 after 31 drops
        busRequests = 32'h8000_0001;
        tick();
        chk32("t2_grant31", busGrants, 32'h8000_0000);
        busRequests = 32'h0000_0001;
        tick();
        chk32("t2_grant_off", busGrants, 32'h0);
        beginTransactionIn = 1'b1; addressDataIn = 2'b00; burstSizeIn = 8'd7;
        tick();
        beginTransactionIn = 1'b0;
        chk1("t2_snoop_set", snoopableBurst, 1'b1);
        tick();
        chk1("t2_snoop_hold", snoopableBurst, 1'b1);
        chk32("t2_no_grant_busy", busGrants, 32'h0);
        endTransactionIn = 1'b1;
        tick();
        endTransactionIn = 1'b0;
        chk1("t2_snoop_clr", snoopableBurst, 1'b0);
        chk1("t2_idle", busIdle, 1'b1);
        chk32("t2_grant_wait", busGrants, 32'h0);
        tick();
        chk32("t2_grant0", busGrants, 32'h0000_0001);
        busRequests = '0;
        tick();
        beginTransactionIn = 1'b1; addressDataIn = 2'b01; burstSizeIn = 8'd7;
        tick();
        beginTransactionIn = 1'b0;
        chk1("t2_snoop_noncache", snoopableBurst, 1'b0);
        chk1("t2_idle_busy", busIdle, 1'b0);
        endTransactionIn = 1'b1;
        tick();
        endTransactionIn = 1'b0;
        chk1("t2_idle_end", busIdle, 1'b1);

        // No begin within 16 cycles: silent release, then lower request served
        busRequests = 32'h0000_0104;
        tick();
        chk32("t3_grant8", busGrants, 32'h0000_0100);
        busRequests = 32'h0000_0004;
        tick();
        for (int i = 1; i < 16; i++) begin
            tick();
            chk1("t3_wait_idle", busIdle, 1'b0);
            chk1("t3_wait_err", busErrorOut, 1'b0);
        end
        tick();
        chk1("t3_release_idle", busIdle, 1'b1);
        chk1("t3_release_err", busErrorOut, 1'b0);
        chk1("t3_release_eot", endTransactionOut, 1'b0);
        chk32("t3_release_grants", busGrants, 32'h0);
        tick();
        chk32("t3_grant2", busGrants, 32'h0000_0004);
        busRequests = '0;
        tick();

        // Silent transaction: watchdog abort (or indefinite wait)
        beginTransactionIn = 1'b1; addressDataIn = 2'b10; burstSizeIn = 8'd3;
        tick();
        beginTransactionIn = 1'b0;
        chk1("t4_idle_busy", busIdle, 1'b0);
        chk1("t4_snoop", snoopableBurst, 1'b0);
        for (int i = 1; i < 256; i++) begin
            tick();
            chk1("t4_silent_err", busErrorOut, 1'b0);
        end
        tick();
`ifdef BUS_WATCHDOG_EN
        chk1("t4_err_pulse", busErrorOut, 1'b1);
        chk1("t4_eot_early", endTransactionOut, 1'b0);
        chk1("t4_idle_err", busIdle, 1'b0);
        tick();
        chk1("t4_err_drop", busErrorOut, 1'b0);
        chk1("t4_eot_pulse", endTransactionOut, 1'b1);
        chk1("t4_idle_eot", busIdle, 1'b0);
        tick();
        chk1("t4_eot_drop", endTransactionOut, 1'b0);
        chk1("t4_idle_after", busIdle, 1'b1);
`else
        chk1("t4_no_err", busErrorOut, 1'b0);
        chk1("t4_still_busy", busIdle, 1'b0);
        tick();
        chk1("t4_no_eot", endTransactionOut, 1'b0);
        chk1("t4_still_busy2", busIdle, 1'b0);
        endTransactionIn = 1'b1;
        tick();
        endTransactionIn = 1'b0;
        chk1("t4_idle_after", busIdle, 1'b1);
`endif

        // Data-valid restarts the watchdog; end coincident with expiry wins
        busRequests = 32'h0000_0010;
        tick();
        chk32("t5_grant4", busGrants, 32'h0000_0010);
        busRequests = '0;
        tick();
        beginTransactionIn = 1'b1; addressDataIn = 2'b00; burstSizeIn = 8'd1;
        tick();
        beginTransactionIn = 1'b0;
        chk1("t5_snoop", snoopableBurst, 1'b1);
        repeat (200) tick();
        dataValidIn = 1'b1;
        tick();
        dataValidIn = 1'b0;
        for (int i = 0; i < 255; i++) begin
            tick();
            chk1("t5_restart_err", busErrorOut, 1'b0);
        end
        endTransactionIn = 1'b1;
        tick();
        endTransactionIn = 1'b0;
        chk1("t5_end_wins_err", busErrorOut, 1'b0);
        chk1("t5_end_wins_idle", busIdle, 1'b1);
        chk1("t5_snoop_clr", snoopableBurst, 1'b0);
        tick();
        chk1("t5_no_eot", endTransactionOut, 1'b0);
        chk1("t5_no_err_late", busErrorOut, 1'b0);

        // Reset during a grant pulse and during a snoopable transaction
        busRequests = 32'h0000_0040;
        tick();
        chk32("t6_grant6", busGrants, 32'h0000_0040);
        busRequests = '0;
        #2 reset = 1'b0;
        #1;
        chk32("t6_rst_grant", busGrants, 32'h0);
        chk1("t6_rst_idle_g", busIdle, 1'b1);
        tick();
        reset = 1'b1;
        busRequests = 32'h0000_0020;
        tick();
        chk32("t6_grant5", busGrants, 32'h0000_0020);
        busRequests = '0;
        tick();
        beginTransactionIn = 1'b1; addressDataIn = 2'b00; burstSizeIn = 8'd5;
        tick();
        beginTransactionIn = 1'b0;
        chk1("t6_snoop_set", snoopableBurst, 1'b1);
        #2 reset = 1'b0;
        #1;
        chk1("t6_rst_idle", busIdle, 1'b1);
        chk1("t6_rst_snoop", snoopableBurst, 1'b0);
        tick();
        reset = 1'b1;
        tick();
        chk1("t6_idle_after", busIdle, 1'b1);
        chk32("t6_grants_after", busGrants, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/bus_arbiter.md
Name: bus_arbiter

Overview:
Central arbiter of the shared system bus. It grants bus ownership to one of 32 masters by fixed priority and tracks the transaction until it ends. It reports bus idle/snoop status and runs a watchdog that aborts hung transactions with an error plus end-of-transaction. The debug bridge (ADBG) sits on request line 31; slaves and other masters share the OR'd bus signals.

Parameters:
NUM_MASTERS, 32, number of request/grant lines (fixed; index 31 = highest priority)
BEGIN_WAIT, 16, cycles allowed between grant and beginTransactionIn
TIMEOUT_CYCLES, 256, watchdog cycles without dataValidIn/endTransactionIn before abort

Ports:
clock  in  1  system bus clock, all logic on rising edge
reset  in  1  asynchronous, active-low reset
busRequests  in  32  request per master, level, held until served
busGrants  out  32  one-hot grant pulse, registered
busErrorOut  out  1  watchdog bus-error pulse, registered
endTransactionOut  out  1  watchdog-generated end-of-transaction pulse, registered
busIdle  out  1  high when no transaction is granted or in progress
snoopableBurst  out  1  current transaction is a cacheable (snoopable) burst
beginTransactionIn  in  1  OR'd bus begin-transaction strobe
endTransactionIn  in  1  OR'd bus end-transaction strobe
dataValidIn  in  1  OR'd bus data-valid strobe
addressDataIn  in  2  bits [31:30] of OR'd address/data bus
burstSizeIn  in  8  OR'd burst size (beats minus 1)

Behaviour:
- Reset (reset=0, async): state IDLE; busGrants=0, busErrorOut=0, endTransactionOut=0, snoopableBurst=0, busIdle=1.
- States: IDLE, GRANT, WAIT_BEGIN, BUSY, ABORT_ERR, ABORT_END.
- IDLE: if busRequests!=0, select highest set index (31 wins over 0), go GRANT. busIdle=1 only in IDLE.
- GRANT: busGrants has exactly the selected bit set for exactly one cycle; next state WAIT_BEGIN. Grant appears the cycle after the request is sampled in IDLE.
- WAIT_BEGIN: on beginTransactionIn go BUSY, latch snoopableBurst = (addressDataIn==2'b00) && (burstSizeIn!=0). If no begin within BEGIN_WAIT cycles return to IDLE silently (no error).
- BUSY: on endTransactionIn go IDLE next cycle, clear snoopableBurst. Watchdog counter cleared on entry and on every dataValidIn; on reaching TIMEOUT_CYCLES go ABORT_ERR.
- ABORT_ERR: busErrorOut=1 one cycle → ABORT_END: endTransactionOut=1 one cycle → IDLE.
- endTransactionIn arriving in the same cycle as the timeout: the end wins; no error.
- beginTransactionIn outside WAIT_BEGIN is ignored.
- Requests change freely; only the value sampled in IDLE matters. Master must drop the request after its grant or it will be re-granted after the transaction.
- No starvation protection: fixed priority is the requirement.
- Reset mid-transaction: immediate return to IDLE, all pulses cleared.

Optional Feature:
BUS_WATCHDOG_EN: when defined, the BUSY watchdog and ABORT_ERR/ABORT_END states exist as above. When undefined, BUSY waits indefinitely for endTransactionIn; busErrorOut and endTransactionOut are tied to 0. The WAIT_BEGIN timeout is present in both builds.

Test Plan:
- Reset: hold reset=0 → busGrants=0, busIdle=1, busErrorOut=0, endTransactionOut=0.
- busRequests=0x8000_0000 → busGrants=0x8000_0000 for one cycle, one cycle later. Then begin with addressDataIn=2'b00 and burstSizeIn=0 → busIdle=0, snoopableBurst=0. Then dataValidIn, then endTransactionIn → busIdle=1 one cycle later.
- busRequests=0x8000_0001 simultaneously → grant 0x8000_0000 first; bit 0 granted after that transaction ends and bit 31 has dropped.
- Begin with addressDataIn=2'b00 and burstSizeIn=8'd7 → snoopableBurst=1 until the end; with addressDataIn=2'b01 → 0.
- With BUS_WATCHDOG_EN: grant, begin, then silence for 256 cycles → busErrorOut pulse, next cycle endTransactionOut pulse, then busIdle=1.
- Grant issued, no beginTransactionIn for 16 cycles → return to IDLE, no error; pending lower request granted next.
